// File: rtl/dma_periph_req_sched_if.sv
// Request/offer/clear signal bundle between the peripheral request scheduler and its neighbours.
// master = scheduler side, slave = peripheral/channel-engine/register side.
interface dma_periph_req_sched_if #(
    parameter int unsigned NUM_PERIPH = 31
);
    logic                  enable;
    logic [NUM_PERIPH-1:0] tx_mask;
    logic [NUM_PERIPH-1:0] rx_mask;
    logic [NUM_PERIPH-1:0] periph_tx_req;
    logic [NUM_PERIPH-1:0] periph_rx_req;
    logic [NUM_PERIPH-1:0] periph_tx_clr;
    logic [NUM_PERIPH-1:0] periph_rx_clr;
    logic                  sel_valid;
    logic                  sel_ready;
    logic [4:0]            sel_periph;
    logic                  sel_dir;
    logic                  xfer_done;
    logic                  xfer_err;
    logic                  err_flag;
    logic                  busy;

    modport master (
        input  enable, tx_mask, rx_mask, periph_tx_req, periph_rx_req,
        input  sel_ready, xfer_done, xfer_err,
        output periph_tx_clr, periph_rx_clr, sel_valid, sel_periph, sel_dir, err_flag, busy
    );

    modport slave (
        output enable, tx_mask, rx_mask, periph_tx_req, periph_rx_req,
        output sel_ready, xfer_done, xfer_err,
        input  periph_tx_clr, periph_rx_clr, sel_valid, sel_periph, sel_dir, err_flag, busy
    );
endinterface

// File: rtl/dma_periph_req_sched.sv
// Round-robin scheduler for peripheral tx/rx flow-control requests: offers one slot at a time to
// the channel engine, waits for the transfer to finish, then pulses the matching clear line.
module dma_periph_req_sched #(
    parameter int unsigned NUM_PERIPH = 31,
    parameter int unsigned HOLDOFF    = 4
) (
    input logic                    clk,
    input logic                    reset,
    dma_periph_req_sched_if.master bus
);
    localparam int unsigned NumSlots = 2 * NUM_PERIPH;
    localparam int unsigned SlotW    = $clog2(NumSlots);

    typedef enum logic [1:0] {StIdle, StOffer, StActive, StClear} state_e;

    state_e           state_q, state_d;
    logic [SlotW-1:0] rr_q, rr_d;
    logic [SlotW-1:0] slot_q, slot_d;
    logic [SlotW-1:0] last_slot_q, last_slot_d;
    logic [3:0]       holdoff_q, holdoff_d;
    logic [4:0]       sel_periph_q, sel_periph_d;
    logic             sel_dir_q, sel_dir_d;
    logic             err_q, err_d;
    logic             enable_q;

    logic [NumSlots-1:0] eligible;
    logic                pick_found;
    logic [SlotW-1:0]    pick_slot;

    // Even slot = tx, odd slot = rx of the same peripheral.
    always_comb begin
        eligible = '0;
        for (int unsigned k = 0; k < NUM_PERIPH; k++) begin
            eligible[2*k]   = bus.periph_tx_req[k] & bus.tx_mask[k];
            eligible[2*k+1] = bus.periph_rx_req[k] & bus.rx_mask[k];
        end
        if (holdoff_q != '0) eligible[last_slot_q] = 1'b0;
    end

    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_slot  = '0;
        for (int unsigned i = 0; i < NumSlots; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NumSlots) idx = idx - NumSlots;
            if (!pick_found && eligible[idx[SlotW-1:0]]) begin
                pick_found = 1'b1;
                pick_slot  = idx[SlotW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        slot_d       = slot_q;
        last_slot_d  = last_slot_q;
        holdoff_d    = (holdoff_q != '0) ? holdoff_q - 4'd1 : holdoff_q;
        sel_periph_d = sel_periph_q;
        sel_dir_d    = sel_dir_q;
        err_d        = err_q;
        if (enable_q && !bus.enable) err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.enable && pick_found) begin
                    slot_d       = pick_slot;
                    sel_periph_d = 5'(pick_slot >> 1) + 5'd1;
                    sel_dir_d    = pick_slot[0];
                    state_d      = StOffer;
                end
            end
            StOffer: begin
                if (bus.sel_ready) state_d = StActive;
            end
            StActive: begin
                if (bus.xfer_done) begin
                    if (bus.xfer_err) err_d = 1'b1;
                    state_d = StClear;
                end
            end
            StClear: begin
                last_slot_d = slot_q;
                holdoff_d   = 4'(HOLDOFF);
                rr_d        = (32'(slot_q) == NumSlots - 1) ? '0 : slot_q + 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            rr_q         <= '0;
            slot_q       <= '0;
            last_slot_q  <= '0;
            holdoff_q    <= '0;
            sel_periph_q <= '0;
            sel_dir_q    <= 1'b0;
            err_q        <= 1'b0;
            enable_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            slot_q       <= slot_d;
            last_slot_q  <= last_slot_d;
            holdoff_q    <= holdoff_d;
            sel_periph_q <= sel_periph_d;
            sel_dir_q    <= sel_dir_d;
            err_q        <= err_d;
            enable_q     <= bus.enable;
        end
    end

    always_comb begin
        bus.periph_tx_clr = '0;
        bus.periph_rx_clr = '0;
        if (state_q == StClear) begin
            if (sel_dir_q) bus.periph_rx_clr[sel_periph_q - 5'd1] = 1'b1;
            else           bus.periph_tx_clr[sel_periph_q - 5'd1] = 1'b1;
        end
    end

    assign bus.sel_valid  = (state_q == StOffer);
    assign bus.sel_periph = sel_periph_q;
    assign bus.sel_dir    = sel_dir_q;
    assign bus.err_flag   = err_q;
    assign bus.busy       = (state_q != StIdle);
endmodule

// File: tb/tb_dma_periph_req_sched.sv
// Bench for dma_periph_req_sched: directed scenarios plus randomized request patterns checked
// against a slot-level round-robin model with timestamp-free holdoff bookkeeping.
module tb_dma_periph_req_sched;
    localparam int unsigned N     = 31;
    localparam int unsigned HOLD  = 4;
    localparam int          NSLOT = 2 * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // Model state: next slot to search from, last served slot, holdoff live, sticky error.
    int m_rr   = 0;
    int m_last = -1;
    bit m_hold = 1'b0;
    bit m_err  = 1'b0;

    dma_periph_req_sched_if #(.NUM_PERIPH(N)) bus ();

    dma_periph_req_sched #(.NUM_PERIPH(N), .HOLDOFF(HOLD)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] bitv(input int p);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << p;
    endfunction

    function automatic int model_pick(input logic [N-1:0] etx, input logic [N-1:0] erx,
                                      input int rr, input int excl);
        for (int i = 0; i < NSLOT; i++) begin
            int s;
            logic [N-1:0] v;
            s = (rr + i) % NSLOT;
            v = (s % 2 == 0) ? (etx >> (s / 2)) : (erx >> (s / 2));
            if (s != excl && v[0]) return s;
        end
        return -1;
    endfunction

    task automatic drive(input logic [N-1:0] tx, input logic [N-1:0] txm,
                         input logic [N-1:0] rx, input logic [N-1:0] rxm);
        bus.periph_tx_req = tx;
        bus.tx_mask       = txm;
        bus.periph_rx_req = rx;
        bus.rx_mask       = rxm;
    endtask

    task automatic do_reset();
        bus.enable    = 1'b0;
        bus.sel_ready = 1'b0;
        bus.xfer_done = 1'b0;
        bus.xfer_err  = 1'b0;
        drive('0, '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        m_rr   = 0;
        m_last = -1;
        m_hold = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_served(input int slot);
        m_rr   = (slot + 1) % NSLOT;
        m_last = slot;
        m_hold = 1'b1;
    endtask

    task automatic wait_offer(output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.sel_valid && waited < 40);
    endtask

    task automatic complete_xfer(input int rdy_dly, input int done_dly, input bit err,
                                 output logic [N-1:0] tx_clr, output logic [N-1:0] rx_clr);
        repeat (rdy_dly) @(negedge clk);
        bus.sel_ready = 1'b1;
        @(negedge clk);
        bus.sel_ready = 1'b0;
        repeat (done_dly) @(negedge clk);
        bus.xfer_done = 1'b1;
        bus.xfer_err  = err;
        @(negedge clk);
        bus.xfer_done = 1'b0;
        bus.xfer_err  = 1'b0;
        tx_clr = bus.periph_tx_clr;
        rx_clr = bus.periph_rx_clr;
    endtask

    task automatic test_reset();
        bus.sel_ready = 1'b1;
        bus.xfer_done = 1'b1;
        bus.xfer_err  = 1'b1;
        bus.enable    = 1'b1;
        drive('1, '1, '1, '1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.sel_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.sel_valid); end
        total++; if ({bus.sel_periph, bus.sel_dir} !== 6'd0) begin bad++; $display("FAIL reset_sel: got %0d/%b want 0/0", bus.sel_periph, bus.sel_dir); end
        total++; if ({bus.periph_tx_clr, bus.periph_rx_clr} !== '0) begin bad++; $display("FAIL reset_clr: got %h/%h want 0", bus.periph_tx_clr, bus.periph_rx_clr); end
        total++; if (bus.err_flag !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err_flag); end
        bus.sel_ready = 1'b0;
        bus.xfer_done = 1'b0;
        bus.xfer_err  = 1'b0;
        bus.enable    = 1'b0;
        drive(bitv(1), bitv(1), '0, '0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({bus.sel_valid, bus.busy} !== 2'b00) begin bad++; $display("FAIL disabled_no_offer: got valid/busy %b%b want 00", bus.sel_valid, bus.busy); end
    endtask

    task automatic test_single_tx();
        int w;
        logic [N-1:0] tc, rc;
        do_reset();
        drive(bitv(2), bitv(2), '0, '0);
        bus.enable = 1'b1;
        wait_offer(w);
        total++; if (w !== 1) begin bad++; $display("FAIL single_latency: got %0d want 1", w); end
        total++; if ({bus.sel_periph, bus.sel_dir} !== {5'd3, 1'b0}) begin bad++; $display("FAIL single_sel: got %0d/%b want 3/0", bus.sel_periph, bus.sel_dir); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", bus.busy); end
        complete_xfer(2, 3, 1'b0, tc, rc);
        total++; if (tc !== 31'h4) begin bad++; $display("FAIL single_tx_clr: got %h want 00000004", tc); end
        total++; if (rc !== '0) begin bad++; $display("FAIL single_rx_clr: got %h want 0", rc); end
        drive('0, '0, '0, '0);
        @(negedge clk);
        total++; if ({bus.periph_tx_clr, bus.busy} !== '0) begin bad++; $display("FAIL single_clr_one_cycle: got %h busy %b want 0", bus.periph_tx_clr, bus.busy); end
    endtask

    task automatic test_round_robin();
        int w;
        int exp_p[4] = '{1, 3, 5, 1};
        bit exp_d[4] = '{0, 1, 0, 0};
        int exp_w[4] = '{1, 2, 2, 2};
        logic [N-1:0] tc, rc;
        do_reset();
        drive(bitv(0) | bitv(4), '1, bitv(2), '1);
        bus.enable = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_offer(w);
            total++; if (w !== exp_w[g]) begin bad++; $display("FAIL rr_latency[%0d]: got %0d want %0d", g, w, exp_w[g]); end
            total++; if (int'(bus.sel_periph) !== exp_p[g] || bus.sel_dir !== exp_d[g]) begin
                bad++; $display("FAIL rr_grant[%0d]: got %0d/%b want %0d/%b", g, bus.sel_periph, bus.sel_dir, exp_p[g], exp_d[g]);
            end
            complete_xfer(0, 1, 1'b0, tc, rc);
            total++; if (tc !== (exp_d[g] ? '0 : bitv(exp_p[g] - 1)) || rc !== (exp_d[g] ? bitv(exp_p[g] - 1) : '0)) begin
                bad++; $display("FAIL rr_clr[%0d]: got %h/%h", g, tc, rc);
            end
        end
    endtask

    task automatic test_holdoff();
        int w;
        logic [N-1:0] tc, rc;
        do_reset();
        drive('0, '0, bitv(1), '1);
        bus.enable = 1'b1;
        wait_offer(w);
        total++; if (w !== 1) begin bad++; $display("FAIL hold_first_latency: got %0d want 1", w); end
        complete_xfer(1, 0, 1'b0, tc, rc);
        total++; if (rc !== 31'h2) begin bad++; $display("FAIL hold_rx_clr: got %h want 00000002", rc); end
        wait_offer(w);
        total++; if (w !== HOLD + 2) begin bad++; $display("FAIL hold_reoffer_latency: got %0d want %0d", w, HOLD + 2); end
        total++; if ({bus.sel_periph, bus.sel_dir} !== {5'd2, 1'b1}) begin bad++; $display("FAIL hold_reoffer_sel: got %0d/%b want 2/1", bus.sel_periph, bus.sel_dir); end
        complete_xfer(0, 0, 1'b0, tc, rc);
    endtask

    task automatic test_backpressure();
        int w;
        logic [N-1:0] tc, rc;
        do_reset();
        drive(bitv(6), '1, bitv(9), '1);
        bus.enable = 1'b1;
        wait_offer(w);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) drive('0, '1, '0, '1);
            if (i == 3) drive('0, '0, '0, '0);
            if (i == 5) bus.enable = 1'b0;
            bus.xfer_done = (i == 7);
            @(negedge clk);
            total++; if ({bus.sel_valid, bus.sel_periph, bus.sel_dir} !== {1'b1, 5'd7, 1'b0}) begin
                bad++; $display("FAIL bp_stable[%0d]: got %b/%0d/%b want 1/7/0", i, bus.sel_valid, bus.sel_periph, bus.sel_dir);
            end
        end
        bus.xfer_done = 1'b0;
        bus.enable    = 1'b1;
        complete_xfer(0, 2, 1'b0, tc, rc);
        total++; if (tc !== bitv(6) || rc !== '0) begin bad++; $display("FAIL bp_clr: got %h/%h want %h/0", tc, rc, bitv(6)); end
    endtask

    task automatic test_error();
        int w;
        logic [N-1:0] tc, rc;
        do_reset();
        drive(bitv(8), bitv(8), '0, '0);
        bus.enable = 1'b1;
        wait_offer(w);
        bus.xfer_err = 1'b1;
        complete_xfer(1, 2, 1'b1, tc, rc);
        total++; if (bus.err_flag !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", bus.err_flag); end
        total++; if (tc !== bitv(8)) begin bad++; $display("FAIL err_clr_pulse: got %h want %h", tc, bitv(8)); end
        drive('0, '0, '0, '0);
        repeat (3) @(negedge clk);
        total++; if (bus.err_flag !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", bus.err_flag); end
        bus.enable = 1'b0;
        @(negedge clk);
        total++; if (bus.err_flag !== 1'b0) begin bad++; $display("FAIL err_clear_on_disable: got %b want 0", bus.err_flag); end
        bus.enable = 1'b1;
        @(negedge clk);
        total++; if (bus.err_flag !== 1'b0) begin bad++; $display("FAIL err_stays_clear: got %b want 0", bus.err_flag); end
    endtask

    task automatic test_reset_active();
        int w;
        logic [N-1:0] tc, rc;
        do_reset();
        drive(bitv(0) | bitv(3) | bitv(5), '1, '0, '0);
        bus.enable = 1'b1;
        wait_offer(w);
        complete_xfer(0, 0, 1'b0, tc, rc);
        wait_offer(w);
        total++; if (int'(bus.sel_periph) !== 4) begin bad++; $display("FAIL ra_second_grant: got %0d want 4", bus.sel_periph); end
        bus.sel_ready = 1'b1;
        @(negedge clk);
        bus.sel_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({bus.busy, bus.sel_valid} !== 2'b00) begin bad++; $display("FAIL ra_reset_idle: got busy/valid %b%b want 00", bus.busy, bus.sel_valid); end
        bus.xfer_done = 1'b1;
        @(negedge clk);
        total++; if ({bus.periph_tx_clr, bus.periph_rx_clr} !== '0) begin bad++; $display("FAIL ra_no_clr: got %h/%h want 0", bus.periph_tx_clr, bus.periph_rx_clr); end
        bus.xfer_done = 1'b0;
        rst_n = 1'b1;
        wait_offer(w);
        total++; if (w !== 1 || int'(bus.sel_periph) !== 1) begin bad++; $display("FAIL ra_restart_slot0: got periph %0d after %0d cycles want 1 after 1", bus.sel_periph, w); end
        total++; if ({bus.periph_tx_clr, bus.periph_rx_clr} !== '0) begin bad++; $display("FAIL ra_clr_after_release: got %h/%h want 0", bus.periph_tx_clr, bus.periph_rx_clr); end
        complete_xfer(0, 0, 1'b0, tc, rc);
        total++; if (tc !== bitv(0)) begin bad++; $display("FAIL ra_final_clr: got %h want %h", tc, bitv(0)); end
    endtask

    task automatic test_random();
        int w, exp, exp_w, s;
        bit err;
        logic [N-1:0] tx, rx, txm, rxm, tc, rc, exp_tc, exp_rc;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            tx  = N'($urandom & $urandom & $urandom);
            rx  = N'($urandom & $urandom & $urandom);
            txm = N'($urandom | $urandom);
            rxm = N'($urandom | $urandom);
            if (m_hold && $urandom_range(0, 3) == 0) begin
                tx = (m_last % 2 == 0) ? bitv(m_last / 2) : '0;
                rx = (m_last % 2 == 1) ? bitv(m_last / 2) : '0;
                txm = '1;
                rxm = '1;
            end
            if (((tx & txm) | (rx & rxm)) == '0) begin
                s = $urandom_range(0, NSLOT - 1);
                if (s % 2 == 0) begin tx |= bitv(s / 2); txm |= bitv(s / 2); end
                else            begin rx |= bitv(s / 2); rxm |= bitv(s / 2); end
            end
            exp = model_pick(tx & txm, rx & rxm, m_rr, m_hold ? m_last : -1);
            if (exp < 0) begin
                exp   = m_last;
                exp_w = HOLD + 2;
            end else begin
                exp_w = m_hold ? 2 : 1;
            end
            drive(tx, txm, rx, rxm);
            bus.enable = 1'b1;
            wait_offer(w);
            total++; if (w !== exp_w) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, w, exp_w); end
            total++; if (int'(bus.sel_periph) !== exp / 2 + 1 || bus.sel_dir !== 1'(exp % 2)) begin
                bad++; $display("FAIL rand_grant[%0d]: got %0d/%b want %0d/%0d", it, bus.sel_periph, bus.sel_dir, exp / 2 + 1, exp % 2);
            end
            err = ($urandom_range(0, 5) == 0);
            complete_xfer($urandom_range(0, 3), $urandom_range(0, 3), err, tc, rc);
            exp_tc = (exp % 2 == 0) ? bitv(exp / 2) : '0;
            exp_rc = (exp % 2 == 1) ? bitv(exp / 2) : '0;
            m_err |= err;
            total++; if (tc !== exp_tc || rc !== exp_rc) begin bad++; $display("FAIL rand_clr[%0d]: got %h/%h want %h/%h", it, tc, rc, exp_tc, exp_rc); end
            total++; if (bus.err_flag !== m_err) begin bad++; $display("FAIL rand_err[%0d]: got %b want %b", it, bus.err_flag, m_err); end
            model_served(exp);
            if ($urandom_range(0, 5) == 0) begin
                bus.enable = 1'b0;
                m_err      = 1'b0;
                repeat (HOLD + 2) @(negedge clk);
                total++; if ({bus.sel_valid, bus.err_flag} !== 2'b00) begin bad++; $display("FAIL rand_disabled[%0d]: got valid/err %b%b want 00", it, bus.sel_valid, bus.err_flag); end
                m_hold = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_round_robin();
        test_holdoff();
        test_backpressure();
        test_error();
        test_reset_active();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
